// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequential single-precision FPU.
// The state enum, op encodings and IEEE-754 constants live here so the top and bench agree.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    EXEC,
    NORM,
    PACK,
    DONE
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_FADD = 2'b01;
  localparam logic [1:0] OP_FMUL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;

  // Flags follow the integer ALU layout {N,Z,C,V}; carry has no meaning here.
  function automatic logic [3:0] makeFlags(input logic [31:0] res, input logic ovf);
    return {res[31], (res[30:0] == 31'd0), 1'b0, ovf};
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational 48-bit leading-zero counter used by the normalisation step.
// An all-zero input reports 48.
module fpu_lzc (
  input  logic [47:0] i_value,
  output logic [5:0]  o_count
);

  // Ascending scan: the highest set bit is visited last and wins.
  always_comb begin
    o_count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (i_value[i]) o_count = 6'(47 - i);
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle FADD/FMUL unit driven by a one-cycle Start pulse.
// Truncating rounding, denormals flushed to zero, Inf/NaN inputs give a quiet NaN.
module fpu_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  FPUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Busy,
  output logic [3:0]  FPUFlags
);

  state_t r_state;
  state_t w_nextState;

  logic [1:0]         r_op;
  logic [31:0]        r_srcA;
  logic [31:0]        r_srcB;
  logic               r_signA;
  logic               r_signB;
  logic [7:0]         r_expA;
  logic [7:0]         r_expB;
  logic [24:0]        r_manA;
  logic [24:0]        r_manB;
  logic               r_special;
  logic               r_sign;
  logic signed [11:0] r_exp;
  logic [47:0]        r_mant;
  logic [31:0]        r_result;
  logic [3:0]         r_flags;

  logic               w_accept;
  logic [7:0]         w_expA;
  logic [7:0]         w_expB;
  logic               w_aGeB;
  logic [7:0]         w_diff;
  logic [24:0]        w_small;
  logic [24:0]        w_aligned;
  logic [25:0]        w_sumMag;
  logic               w_sumSign;
  logic [47:0]        w_product;
  logic signed [11:0] w_mulExp;
  logic [5:0]         w_lz;
  logic [5:0]         w_lzm1;
  logic [47:0]        w_normMant;
  logic signed [11:0] w_normExp;
  logic [31:0]        w_packResult;
  logic               w_packOvf;

  assign w_accept = (r_state == IDLE) && Start && (FPUOp != OP_NONE);

  assign Result   = r_result;
  assign FPUFlags = r_flags;
  assign Done     = (r_state == DONE);
  assign Busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = (FPUOp == OP_RSVD) ? DONE : UNPACK;
      UNPACK:  w_nextState = (r_op == OP_FADD) ? ALIGN : EXEC;
      ALIGN:   w_nextState = EXEC;
      EXEC:    w_nextState = NORM;
      NORM:    w_nextState = PACK;
      PACK:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Mantissas carry the hidden bit at [24] and a guard bit at [0].
  assign w_expA = r_srcA[30:23];
  assign w_expB = r_srcB[30:23];

  // After ALIGN, operand A always holds the larger exponent.
  assign w_aGeB    = (r_expA >= r_expB);
  assign w_diff    = w_aGeB ? (r_expA - r_expB) : (r_expB - r_expA);
  assign w_small   = w_aGeB ? r_manB : r_manA;
  assign w_aligned = (w_diff >= 8'd26) ? 25'd0 : (w_small >> w_diff);

  always_comb begin
    w_sumMag  = 26'd0;
    w_sumSign = r_signA;
    if (r_signA == r_signB) begin
      w_sumMag = {1'b0, r_manA} + {1'b0, r_manB};
    end else if (r_manA >= r_manB) begin
      w_sumMag = {1'b0, r_manA} - {1'b0, r_manB};
    end else begin
      w_sumMag  = {1'b0, r_manB} - {1'b0, r_manA};
      w_sumSign = r_signB;
    end
  end

  assign w_product = {24'd0, r_manA[24:1]} * {24'd0, r_manB[24:1]};
  assign w_mulExp  = $signed({4'd0, r_expA}) + $signed({4'd0, r_expB}) - $signed(12'(BIAS));

  // Both paths place the hidden bit at [46]; a carry lands in [47].
  fpu_lzc u_lzc (
    .i_value (r_mant),
    .o_count (w_lz)
  );

  assign w_lzm1 = w_lz - 6'd1;

  always_comb begin
    w_normMant = r_mant;
    w_normExp  = r_exp;
    if (r_mant[47]) begin
      w_normMant = r_mant >> 1;
      w_normExp  = r_exp + 12'sd1;
    end else if (r_mant != 48'd0) begin
      w_normMant = r_mant << w_lzm1;
      w_normExp  = r_exp - $signed({6'd0, w_lzm1});
    end
  end

  always_comb begin
    w_packResult = 32'd0;
    w_packOvf    = 1'b0;
    if (r_special) begin
      w_packResult = QNAN;
      w_packOvf    = 1'b1;
    end else if (r_mant == 48'd0) begin
      w_packResult = 32'd0;
    end else if (r_exp >= 12'sd255) begin
      w_packResult = {r_sign, INF_EXP, 23'd0};
      w_packOvf    = 1'b1;
    end else if (r_exp <= 12'sd0) begin
      w_packResult = 32'd0;
    end else begin
      w_packResult = {r_sign, r_exp[7:0], r_mant[45:23]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op      <= OP_NONE;
      r_srcA    <= 32'd0;
      r_srcB    <= 32'd0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_expA    <= 8'd0;
      r_expB    <= 8'd0;
      r_manA    <= 25'd0;
      r_manB    <= 25'd0;
      r_special <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= 12'sd0;
      r_mant    <= 48'd0;
      r_result  <= 32'd0;
      r_flags   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= FPUOp;
            r_srcA <= SrcA;
            r_srcB <= SrcB;
            if (FPUOp == OP_RSVD) begin
              r_result <= QNAN;
              r_flags  <= makeFlags(QNAN, 1'b1);
            end
          end
        end
        UNPACK: begin
          r_signA   <= r_srcA[31];
          r_signB   <= r_srcB[31];
          r_expA    <= w_expA;
          r_expB    <= w_expB;
          r_manA    <= (w_expA == 8'd0) ? 25'd0 : {1'b1, r_srcA[22:0], 1'b0};
          r_manB    <= (w_expB == 8'd0) ? 25'd0 : {1'b1, r_srcB[22:0], 1'b0};
          r_special <= (w_expA == INF_EXP) || (w_expB == INF_EXP);
        end
        ALIGN: begin
          r_manB <= w_aligned;
          if (w_aGeB) begin
            r_exp <= $signed({4'd0, r_expA});
          end else begin
            r_exp   <= $signed({4'd0, r_expB});
            r_manA  <= r_manB;
            r_signA <= r_signB;
            r_signB <= r_signA;
          end
        end
        EXEC: begin
          if (r_op == OP_FADD) begin
            r_mant <= {w_sumMag, 22'd0};
            r_sign <= w_sumSign;
          end else begin
            r_mant <= w_product;
            r_exp  <= w_mulExp;
            r_sign <= r_signA ^ r_signB;
          end
        end
        NORM: begin
          r_mant <= w_normMant;
          r_exp  <= w_normExp;
        end
        PACK: begin
          r_result <= w_packResult;
          r_flags  <= makeFlags(w_packResult, w_packOvf);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq: directed protocol cases plus random FADD/FMUL
// compared against an arithmetic reference model.
module tb_fpu_seq;

  localparam logic [1:0]  TB_FADD = 2'b01;
  localparam logic [1:0]  TB_FMUL = 2'b10;
  localparam logic [1:0]  TB_RSVD = 2'b11;
  localparam logic [31:0] TB_QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  FPUOp = 2'b00;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic [31:0] Result;
  logic        Done;
  logic        Busy;
  logic [3:0]  FPUFlags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .FPUOp    (FPUOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Result   (Result),
    .Done     (Done),
    .Busy     (Busy),
    .FPUFlags (FPUFlags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on unpacked fields; returns {V, result}.
  function automatic logic [32:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, d;
    longint ma, mb, va, vb, sum, mag;
    logic s;
    logic [22:0] frac;
    if (op == TB_RSVD) return {1'b1, TB_QNAN};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, TB_QNAN};
    ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
    if (op == TB_FMUL) begin
      if (ma == 0 || mb == 0) return 33'd0;
      mag = ma * mb;
      e   = ea + eb - 127;
      s   = a[31] ^ b[31];
      if (mag >= (64'sd1 << 47)) begin
        mag = mag >> 1;
        e++;
      end
      frac = mag[45:23];
    end else begin
      ma = ma * 2;
      mb = mb * 2;
      if (ea >= eb) begin
        e  = ea;
        d  = ea - eb;
        mb = (d >= 26) ? 64'sd0 : (mb >> d);
      end else begin
        e  = eb;
        d  = eb - ea;
        ma = (d >= 26) ? 64'sd0 : (ma >> d);
      end
      va  = a[31] ? -ma : ma;
      vb  = b[31] ? -mb : mb;
      sum = va + vb;
      if (sum == 0) return 33'd0;
      s   = (sum < 0);
      mag = s ? -sum : sum;
      while (mag >= (64'sd1 << 25)) begin
        mag = mag >> 1;
        e++;
      end
      while (mag < (64'sd1 << 24)) begin
        mag = mag << 1;
        e--;
      end
      frac = mag[23:1];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return 33'd0;
    return {1'b0, s, e[7:0], frac};
  endfunction

  // Pulses Start for one edge, scrambles the operands afterwards, and waits for Done.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res, output logic [3:0] flg,
                               output logic busyAfter);
    @(negedge clk);
    Start = 1'b1;
    FPUOp = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    #1;
    Start     = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    FPUOp     = 2'($urandom);
    busyAfter = Busy;
    lat       = 1;
    while (!Done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = Result;
    flg = FPUFlags;
    @(posedge clk);
    #1;
  endtask

  task automatic runDirected(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expRes, input logic [3:0] expFlg, input int expLat);
    int lat;
    logic [31:0] res;
    logic [3:0] flg;
    logic busyAfter;
    applyStimulus(op, a, b, lat, res, flg, busyAfter);
    checkOutput({tag, ".result"}, res, expRes);
    checkOutput({tag, ".flags"}, 32'(flg), 32'(expFlg));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".busy"}, 32'(busyAfter), 32'd1);
  endtask

  task automatic runRandom(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] res;
    logic [3:0] flg;
    logic busyAfter;
    logic [32:0] m;
    applyStimulus(op, a, b, lat, res, flg, busyAfter);
    m = refModel(op, a, b);
    checkOutput({tag, ".result"}, res, m[31:0]);
    checkOutput({tag, ".flags"}, 32'(flg), 32'({m[31], (m[30:0] == 31'd0), 1'b0, m[32]}));
    checkOutput({tag, ".latency"}, 32'(lat), (op == TB_FADD) ? 32'd6 : 32'd5);
  endtask

  function automatic logic [31:0] randOperand();
    int sel;
    logic [7:0] e;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(230, 254));
      4, 5:    e = 8'($urandom_range(1, 20));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    int doneCnt, busyCnt, lat;
    logic [31:0] captured;
    logic [31:0] a, b;
    logic [1:0] op;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.result", Result, 32'd0);
    checkOutput("reset.flags", 32'(FPUFlags), 32'd0);
    checkOutput("reset.done", 32'(Done), 32'd0);
    checkOutput("reset.busy", 32'(Busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runDirected("fadd_1p1", TB_FADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 6);
    runDirected("fmul_1p5x2", TB_FMUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 5);
    runDirected("fadd_cancel", TB_FADD, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4'b0100, 6);
    runDirected("fmul_ovf", TB_FMUL, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0001, 5);
    runDirected("rsvd", TB_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, TB_QNAN, 4'b0001, 1);
    runDirected("fadd_inf", TB_FADD, 32'h7F80_0000, 32'h3F80_0000, TB_QNAN, 4'b0001, 6);
    runDirected("fmul_under", TB_FMUL, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0100, 5);
    runDirected("fadd_neg", TB_FADD, 32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 4'b1000, 6);
    runDirected("fadd_denorm", TB_FADD, 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 6);

    // Op 00 with Start must leave the unit idle.
    @(negedge clk);
    Start = 1'b1;
    FPUOp = 2'b00;
    SrcA  = 32'h3F80_0000;
    SrcB  = 32'h3F80_0000;
    busyCnt = 0;
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      Start = 1'b0;
      busyCnt += int'(Busy);
      doneCnt += int'(Done);
    end
    checkOutput("op00.busy", 32'(busyCnt), 32'd0);
    checkOutput("op00.done", 32'(doneCnt), 32'd0);

    // FMUL request while an FADD is in flight is dropped.
    @(negedge clk);
    Start = 1'b1;
    FPUOp = TB_FADD;
    SrcA  = 32'h4040_0000;
    SrcB  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    busyCnt  = int'(Busy);
    doneCnt  = int'(Done);
    captured = 32'd0;
    FPUOp = TB_FMUL;
    SrcA  = 32'h4000_0000;
    SrcB  = 32'h4000_0000;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #1;
      Start = 1'b0;
      busyCnt += int'(Busy);
      doneCnt += int'(Done);
      if (Done) captured = Result;
    end
    checkOutput("busy_start.done_count", 32'(doneCnt), 32'd1);
    checkOutput("busy_start.result", captured, 32'h4080_0000);
    checkOutput("busy_start.busy_cycles", 32'(busyCnt), 32'd6);

    // Start asserted during the DONE cycle must be ignored.
    @(negedge clk);
    Start = 1'b1;
    FPUOp = TB_FMUL;
    SrcA  = 32'h3FC0_0000;
    SrcB  = 32'h3FC0_0000;
    @(posedge clk);
    #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("done_start.latency", 32'(lat), 32'd5);
    Start = 1'b1;
    FPUOp = TB_FADD;
    SrcA  = 32'h3F80_0000;
    SrcB  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    Start = 1'b0;
    checkOutput("done_start.busy", 32'(Busy), 32'd0);
    checkOutput("done_start.result", Result, 32'h4010_0000);
    runDirected("after_done", TB_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 6);

    // Reset during EXEC aborts the FADD with no later Done.
    @(negedge clk);
    Start = 1'b1;
    FPUOp = TB_FADD;
    SrcA  = 32'h3F80_0000;
    SrcB  = 32'h4000_0000;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort.busy_exec", 32'(Busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort.result", Result, 32'd0);
    checkOutput("abort.flags", 32'(FPUFlags), 32'd0);
    checkOutput("abort.done", 32'(Done), 32'd0);
    checkOutput("abort.busy", 32'(Busy), 32'd0);
    reset = 1'b1;
    doneCnt = 0;
    busyCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      doneCnt += int'(Done);
      busyCnt += int'(Busy);
    end
    checkOutput("abort.late_done", 32'(doneCnt), 32'd0);
    checkOutput("abort.late_busy", 32'(busyCnt), 32'd0);

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 1) == 0) ? TB_FADD : TB_FMUL;
      a  = randOperand();
      case ($urandom_range(0, 3))
        0:       b = a ^ 32'h8000_0000;
        1:       b = {1'($urandom), a[30:23], 23'($urandom)};
        default: b = randOperand();
      endcase
      runRandom($sformatf("rand%0d", n), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
